// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl: instruction memory with streaming program loader and
// run sequencer (load -> hold core in reset -> run -> done).
// Optional build macro IMEM_REG_READ_EN: registered fetch path with one
// cycle of latency; when undefined the fetch is combinational.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_LOAD | accepting program words, core held in reset
// S_HOLD | program loaded, core held in reset for RST_HOLD cycles
// S_RUN  | core released, fetches served, watchdog counting
// S_DONE | run ended by watchdog or halt word, held until rst
module imem_load_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 1024,
    parameter int                PC_W       = 32,
    parameter int                RST_HOLD   = 3,
    parameter int                MAX_CYCLES = 2500,
    parameter logic [DATA_W-1:0] HALT_WORD  = DATA_W'(32'hFFFF_FFFF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [DATA_W-1:0]          ld_data,
    input  logic                       ld_last,
    input  logic [PC_W-1:0]            pc,
    output logic [DATA_W-1:0]          inst,
    output logic                       cpu_rst,
    output logic                       running,
    output logic                       done,
    output logic                       timeout,
    output logic                       halted,
    output logic                       load_err,
    output logic [$clog2(DEPTH):0]     load_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = PC_W - 2;
    localparam int XW = (IW > CW) ? IW : CW;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     cyc_cnt;

    logic              xfer;
    logic              full;
    logic              wr_en;
    logic              hold_tc;
    logic              cyc_tc;
    logic              halt_hit;
    logic [XW-1:0]     idx_x;
    logic [XW-1:0]     cnt_x;
    logic              hit;
    logic [DATA_W-1:0] rd_word;

    // byte offset within a word never selects anything
    logic              unused_pc_lsb;
    assign unused_pc_lsb = &{1'b0, pc[1:0]};

    // transfer qualification and terminal-count decode
    always_comb begin
        xfer    = ld_valid & ld_ready & (state == S_LOAD);
        full    = (load_count == CW'(DEPTH));
        wr_en   = rst & xfer & ~full;
        hold_tc = (hold_cnt == HW'(RST_HOLD - 1));
        cyc_tc  = (cyc_cnt == TW'(MAX_CYCLES - 1));
    end

    // fetch lookup; anything at or beyond the loaded length reads as NOP
    always_comb begin
        idx_x   = XW'(pc[PC_W-1:2]);
        cnt_x   = XW'(load_count);
        hit     = (idx_x < cnt_x);
        rd_word = '0;
        if (hit) begin
            rd_word = mem[idx_x[AW-1:0]];
        end
    end

    // program storage, deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_count[AW-1:0]] <= ld_data;
        end
    end

`ifdef IMEM_REG_READ_EN
    logic [DATA_W-1:0] inst_q;

    // registered fetch; forced to zero outside RUN and on the cycle RUN ends
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_q <= '0;
        end else if ((state == S_RUN) && !halt_hit && !cyc_tc) begin
            inst_q <= rd_word;
        end else begin
            inst_q <= '0;
        end
    end

    assign inst     = inst_q;
    assign halt_hit = (state == S_RUN) && (inst_q == HALT_WORD);
`else
    assign inst     = (state == S_RUN) ? rd_word : '0;
    assign halt_hit = (state == S_RUN) && (rd_word == HALT_WORD);
`endif

    // sequencer: load, hold core in reset, run under watchdog, then park
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_LOAD;
            load_count <= '0;
            hold_cnt   <= '0;
            cyc_cnt    <= '0;
            ld_ready   <= 1'b1;
            cpu_rst    <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            halted     <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (xfer) begin
                        if (full) begin
                            load_err <= 1'b1;
                        end else begin
                            load_count <= load_count + CW'(1);
                        end
                        if (ld_last) begin
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                            ld_ready <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_tc) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                        cyc_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    // a halt fetch on the watchdog's last cycle counts as a halt
                    if (halt_hit) begin
                        state   <= S_DONE;
                        halted  <= 1'b1;
                        cpu_rst <= 1'b1;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (cyc_tc) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                        cpu_rst <= 1'b1;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    cpu_rst  <= 1'b1;
                    running  <= 1'b0;
                    done     <= 1'b1;
                    ld_ready <= 1'b0;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: a 32-deep instance for load/run/halt/
// reset sequences and a 4-deep instance for the overflow case.
module tb_imem_load_ctrl;

`ifdef IMEM_REG_READ_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    // main instance
    logic        rst = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [31:0] ld_data = '0, pc = '0;
    logic        ld_ready, cpu_rst, running, done, timeout, halted, load_err;
    logic [31:0] inst;
    logic [5:0]  load_count;

    // small instance
    logic        rst_s = 1'b0, ld_valid_s = 1'b0, ld_last_s = 1'b0;
    logic [31:0] ld_data_s = '0, pc_s = '0;
    logic        ld_ready_s, cpu_rst_s, running_s, done_s, timeout_s, halted_s, load_err_s;
    logic [31:0] inst_s;
    logic [2:0]  load_count_s;

    imem_load_ctrl #(.DATA_W(32), .DEPTH(32), .PC_W(32), .RST_HOLD(3),
                     .MAX_CYCLES(10), .HALT_WORD(32'hFFFF_FFFF)) u_dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .pc(pc), .inst(inst),
        .cpu_rst(cpu_rst), .running(running), .done(done), .timeout(timeout),
        .halted(halted), .load_err(load_err), .load_count(load_count));

    imem_load_ctrl #(.DATA_W(32), .DEPTH(4), .PC_W(32), .RST_HOLD(1),
                     .MAX_CYCLES(10), .HALT_WORD(32'hFFFF_FFFF)) u_small (
        .clk(clk), .rst(rst_s), .ld_valid(ld_valid_s), .ld_ready(ld_ready_s),
        .ld_data(ld_data_s), .ld_last(ld_last_s), .pc(pc_s), .inst(inst_s),
        .cpu_rst(cpu_rst_s), .running(running_s), .done(done_s), .timeout(timeout_s),
        .halted(halted_s), .load_err(load_err_s), .load_count(load_count_s));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] prog[16];

    function automatic logic [31:0] w(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h11;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic load_a(input int n);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = prog[i];
            ld_last  = (i == n - 1);
            step();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic wait_running(output int n);
        n = 0;
        while (!running && n < 30) begin
            step();
            n++;
        end
        if (!running) chk("wait_running_bound", 32'(running), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        if (!done) chk("wait_done_bound", 32'(done), 32'd1);
    endtask

    task automatic fetch_chk(input logic [31:0] p, input logic [31:0] e, input string nm);
        pc = p;
`ifdef IMEM_REG_READ_EN
        step();
        chk(nm, inst, e);
`else
        #1;
        chk(nm, inst, e);
        step();
`endif
    endtask

    task automatic fetch_chk_s(input logic [31:0] p, input logic [31:0] e, input string nm);
        pc_s = p;
`ifdef IMEM_REG_READ_EN
        step();
        chk(nm, inst_s, e);
`else
        #1;
        chk(nm, inst_s, e);
        step();
`endif
    endtask

    initial begin
        int          n;
        int          r0;
        logic        rst_ok;
        logic [31:0] prev;

        vecs[0] = '{32'h0000_0008, w(2),  "fetch_pc08"};
        vecs[1] = '{32'h0000_000B, w(2),  "fetch_pc0b_lsb_ignored"};
        vecs[2] = '{32'h0000_0040, 32'h0, "fetch_pc40_unloaded"};
        vecs[3] = '{32'h0000_003C, w(15), "fetch_pc3c_last_loaded"};
        vecs[4] = '{32'h0000_0000, w(0),  "fetch_pc00"};

        // reset state
        step();
        do_reset();
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_flags", {29'd0, timeout, halted, load_err}, 32'd0);

        // load 16 words, then exact hold length with ld_valid left high
        for (int i = 0; i < 16; i++) prog[i] = w(i);
        load_a(16);
        chk("ld16_count", 32'(load_count), 32'd16);
        chk("ld16_ready_drop", 32'(ld_ready), 32'd0);
        chk("ld16_cpu_rst", 32'(cpu_rst), 32'd1);
        ld_valid = 1'b1;
        ld_data  = 32'hDEAD_BEEF;
        n = 0;
        rst_ok = 1'b1;
        while (!running && n < 30) begin
            if (!cpu_rst) rst_ok = 1'b0;
            step();
            n++;
        end
        ld_valid = 1'b0;
        chk("hold_cycles", 32'(n), 32'd3);
        chk("hold_cpu_rst_high", 32'(rst_ok), 32'd1);
        chk("run_cpu_rst_low", 32'(cpu_rst), 32'd0);
        chk("run_count_unchanged", 32'(load_count), 32'd16);
        chk("run_no_load_err", 32'(load_err), 32'd0);
        r0 = cyc;

        // fetch table
        prev = 32'h0;
        for (int i = 0; i < 5; i++) begin
            pc = vecs[i].pc;
`ifdef IMEM_REG_READ_EN
            #1;
            chk({vecs[i].nm, "_before_edge"}, inst, prev);
            step();
            chk(vecs[i].nm, inst, vecs[i].exp);
            prev = vecs[i].exp;
`else
            #1;
            chk(vecs[i].nm, inst, vecs[i].exp);
            step();
`endif
        end

        // watchdog: done exactly 10 cycles after running rose
        pc = 32'h0000_0040;
        wait_done(n);
        chk("to_delay", 32'(cyc - r0), 32'd10);
        chk("to_timeout", 32'(timeout), 32'd1);
        chk("to_halted", 32'(halted), 32'd0);
        chk("to_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("to_running", 32'(running), 32'd0);
        chk("to_inst_zero", inst, 32'd0);
        repeat (3) step();
        chk("to_done_sticky", 32'(done), 32'd1);

        // halt fetched on run cycle 4
        do_reset();
        chk("rst2_done_clear", 32'(done), 32'd0);
        chk("rst2_timeout_clear", 32'(timeout), 32'd0);
        prog[5] = 32'hFFFF_FFFF;
        load_a(8);
        wait_running(n);
        r0 = cyc;
        pc = 32'h0;
        repeat (3) step();
        pc = 32'h0000_0014;
        wait_done(n);
        chk("halt_delay", 32'(cyc - r0), 32'(4 + LAT));
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_timeout", 32'(timeout), 32'd0);
        chk("halt_done", 32'(done), 32'd1);

        // halt on the watchdog's final cycle: halt wins
        do_reset();
        load_a(8);
        wait_running(n);
        r0 = cyc;
        pc = 32'h0;
        repeat (9 - LAT) step();
        pc = 32'h0000_0014;
        wait_done(n);
        chk("both_delay", 32'(cyc - r0), 32'd10);
        chk("both_halted", 32'(halted), 32'd1);
        chk("both_timeout", 32'(timeout), 32'd0);

        // overflow on the 4-deep instance
        rst_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ld_valid_s = 1'b1;
            ld_data_s  = 32'hB000_0000 + 32'(i);
            ld_last_s  = (i == 5);
            step();
        end
        ld_valid_s = 1'b0;
        ld_last_s  = 1'b0;
        chk("ovf_load_err", 32'(load_err_s), 32'd1);
        chk("ovf_load_count", 32'(load_count_s), 32'd4);
        chk("ovf_hold_ready", 32'(ld_ready_s), 32'd0);
        chk("ovf_hold_cpu_rst", 32'(cpu_rst_s), 32'd1);
        chk("ovf_hold_running", 32'(running_s), 32'd0);
        step();
        chk("ovf_run", 32'(running_s), 32'd1);
        for (int i = 0; i < 4; i++) fetch_chk_s(32'(i * 4), 32'hB000_0000 + 32'(i), "ovf_word");
        fetch_chk_s(32'h10, 32'h0, "ovf_beyond_depth");

        // reset mid-run, then a short program must not expose stale words
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = w(i);
        load_a(16);
        wait_running(n);
        repeat (2) step();
        do_reset();
        chk("mid_rst_ready", 32'(ld_ready), 32'd1);
        chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_rst_running", 32'(running), 32'd0);
        chk("mid_rst_count", 32'(load_count), 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        prog[0] = 32'h1234_0000;
        prog[1] = 32'h1234_0001;
        load_a(2);
        chk("reload_count", 32'(load_count), 32'd2);
        wait_running(n);
        chk("reload_hold_cycles", 32'(n), 32'd3);
        fetch_chk(32'h4, 32'h1234_0001, "reload_word1");
        fetch_chk(32'h8, 32'h0, "reload_stale_hidden");
        fetch_chk(32'h0, 32'h1234_0000, "reload_word0");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
